// File: rtl/updown_count_sequencer_if.sv
// Command, configuration and status bundle between the front panel and the
// up/down count sequencer.
interface updown_count_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic             start;
  logic             stop;
  logic             step;
  logic             load;
  logic             dir_sel;
  logic [1:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             running;
  logic             halted;
  logic             tc_pulse;

  modport master (
    output tick, start, stop, step, load, dir_sel, mode, load_val, lo, hi,
    input  count, dir, running, halted, tc_pulse
  );

  modport slave (
    input  tick, start, stop, step, load, dir_sel, mode, load_val, lo, hi,
    output count, dir, running, halted, tc_pulse
  );
endinterface

// File: rtl/updown_count_sequencer.sv
// Run/stop/single-step control FSM with an up/down count between live lo/hi
// limits and a wrap, bounce or stop-at-limit boundary policy.
//
// state | meaning
// IDLE  | count held, waiting for a command
// RUN   | advance on every tick
// STEP  | advance on the next tick, then return to IDLE
// HALT  | stop-at-limit boundary reached; only start/stop/load/reset leave
module updown_count_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  updown_count_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             tc_q, tc_d;

  logic             bad_cfg;
  logic             at_edge;
  logic             m_bounce;
  logic             m_stop;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dir_d    = dir_q;
    tc_d     = 1'b0;
    bad_cfg  = (bus.lo > bus.hi);
    m_bounce = (bus.mode == 2'b01);
    m_stop   = (bus.mode == 2'b10);
    // Out-of-range counts and an inverted lo/hi window both land on the
    // boundary path, so +1/-1 can never overflow.
    at_edge  = bad_cfg || (dir_q ? (count_q >= bus.hi) : (count_q <= bus.lo));

    if (bus.load) begin
      count_d = bus.load_val;
      dir_d   = bus.dir_sel;
      state_d = IDLE;
    end else if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      if (state_q != RUN) begin
        state_d = RUN;
        dir_d   = bus.dir_sel;
      end
    end else if (bus.step) begin
      if (state_q == IDLE) state_d = STEP;
    end else if (bus.tick && (state_q == RUN || state_q == STEP)) begin
      if (state_q == STEP) state_d = IDLE;
      if (!at_edge) begin
        count_d = dir_q ? count_q + 1'b1 : count_q - 1'b1;
      end else begin
        tc_d = 1'b1;
        if (m_stop) begin
          state_d = HALT;
        end else if (m_bounce) begin
          dir_d = ~dir_q;
          if (bus.hi > bus.lo) count_d = dir_q ? count_q - 1'b1 : count_q + 1'b1;
        end else begin
          count_d = dir_q ? bus.lo : bus.hi;
        end
      end
    end

    running_d = (state_d == RUN) || (state_d == STEP);
    halted_d  = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dir_q     <= 1'b1;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      tc_q      <= tc_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.dir      = dir_q;
  assign bus.running  = running_q;
  assign bus.halted   = halted_q;
  assign bus.tc_pulse = tc_q;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Directed-vector bench for updown_count_sequencer with hand-computed
// expected count/dir/running/halted/tc_pulse values.
module tb_updown_count_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;

  updown_count_sequencer_if #(.WIDTH(8)) bus ();

  updown_count_sequencer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v, input logic d);
    bus.load_val = v;
    bus.dir_sel  = d;
    bus.load     = 1'b1;
    cyc();
    bus.load     = 1'b0;
  endtask

  task automatic do_start(input logic d);
    bus.dir_sel = d;
    bus.start   = 1'b1;
    cyc();
    bus.start   = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  task automatic do_step();
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] c, input logic d,
                            input logic r, input logic h, input logic t);
    chk({tag, ".count"},   bus.count,    c);
    chk({tag, ".dir"},     bus.dir,      d);
    chk({tag, ".running"}, bus.running,  r);
    chk({tag, ".halted"},  bus.halted,   h);
    chk({tag, ".tc"},      bus.tc_pulse, t);
  endtask

  initial begin
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.step = 0; bus.load = 0;
    bus.dir_sel = 1; bus.mode = 2'b00; bus.load_val = 8'h00;
    bus.lo = 8'h00; bus.hi = 8'hFF;

    cyc();
    cyc();
    expect_out("rst", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // Asynchronous reset in the middle of RUN
    do_load(8'h37, 1'b0);
    do_start(1'b0);
    expect_out("prerst", 8'h37, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    expect_out("midrst", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // Wrap across the full 8-bit range
    bus.lo = 8'h00; bus.hi = 8'hFF; bus.mode = 2'b00;
    do_load(8'hFE, 1'b1);
    do_start(1'b1);
    do_tick(); expect_out("wrap1", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    do_tick(); expect_out("wrap2", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    do_tick(); expect_out("wrap3", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);

    // Bounce between 0x10 and 0x13
    bus.lo = 8'h10; bus.hi = 8'h13; bus.mode = 2'b01;
    do_load(8'h12, 1'b1);
    chk("bnc.load_idle", bus.running, 1'b0);
    do_start(1'b1);
    do_tick(); expect_out("bnc1", 8'h13, 1'b1, 1'b1, 1'b0, 1'b0);
    do_tick(); expect_out("bnc2", 8'h12, 1'b0, 1'b1, 1'b0, 1'b1);
    do_tick(); expect_out("bnc3", 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    do_tick(); expect_out("bnc4", 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    do_tick(); expect_out("bnc5", 8'h11, 1'b1, 1'b1, 1'b0, 1'b1);
    do_tick(); expect_out("bnc6", 8'h12, 1'b1, 1'b1, 1'b0, 1'b0);

    // Stop-at-limit going down to 0x05
    bus.lo = 8'h05; bus.hi = 8'hFF; bus.mode = 2'b10;
    do_load(8'h06, 1'b0);
    do_start(1'b0);
    do_tick(); expect_out("stp1", 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    do_tick(); expect_out("stp2", 8'h05, 1'b0, 1'b0, 1'b1, 1'b1);
    do_tick(); expect_out("stp3", 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
    do_start(1'b0);
    expect_out("stp_restart", 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);

    // Single step from IDLE
    do_stop();
    bus.lo = 8'h00; bus.hi = 8'hFF; bus.mode = 2'b00;
    do_load(8'h20, 1'b1);
    do_step();
    expect_out("step0", 8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
    do_tick(); expect_out("step1", 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    do_tick(); chk("step2.count", bus.count, 8'h21);
    do_tick(); chk("step3.count", bus.count, 8'h21);

    // start and tick in the same cycle: no advance
    bus.tick = 1'b1;
    do_start(1'b1);
    bus.tick = 1'b0;
    expect_out("st_tick", 8'h21, 1'b1, 1'b1, 1'b0, 1'b0);
    do_tick(); chk("st_tick_next.count", bus.count, 8'h22);

    // step is ignored while running
    do_step();
    chk("step_in_run.running", bus.running, 1'b1);
    do_tick(); chk("step_in_run.count", bus.count, 8'h23);

    // load + stop + tick together: load wins, IDLE
    bus.tick = 1'b1; bus.stop = 1'b1;
    do_load(8'h80, 1'b0);
    bus.tick = 1'b0; bus.stop = 1'b0;
    expect_out("ld_stp_tk", 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    do_tick(); chk("idle_tick.count", bus.count, 8'h80);

    // Inverted window: every advance is a boundary event
    bus.lo = 8'h20; bus.hi = 8'h10; bus.mode = 2'b00;
    do_load(8'h05, 1'b1);
    do_start(1'b1);
    do_tick(); chk("badcfg1.tc", bus.tc_pulse, 1'b1);
    do_tick(); chk("badcfg2.tc", bus.tc_pulse, 1'b1);
    chk("badcfg.running", bus.running, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
